// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - two-phase fetch/execute sequencer with halt/single-step debug
// Optional return stack enabled by defining SEQ_CALL_STACK_EN.
module pc_sequencer #(
  parameter int PC_WIDTH    = 6,
  parameter int STACK_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH:0]   ControlPC,
  input  logic                Call,
  input  logic                Ret,
  input  logic                HaltReq,
  input  logic                StepReq,
  output logic [PC_WIDTH-1:0] PC,
  output logic                Fetch_CE,
  output logic                Exec_CE,
  output logic                Halted,
  output logic                StepDone,
  output logic                StackErr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                step_q, step_d;
  logic                step_done_q, step_done_d;
  logic                step_prev_q, step_prev_d;

  logic                jump_flag;
  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] exec_pc;
  logic                step_rise;

  assign jump_flag   = ControlPC[PC_WIDTH];
  assign jump_target = ControlPC[PC_WIDTH-1:0];
  assign pc_inc      = pc_q + PC_WIDTH'(1);
  // A held StepReq only counts once; a level that was already high before HALT never steps.
  assign step_rise   = StepReq & ~step_prev_q;
  assign step_prev_d = StepReq;

`ifdef SEQ_CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  logic [SP_W-1:0]     sp_q, sp_d;
  logic                err_q, err_d;
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [PC_WIDTH-1:0] stack_d [STACK_DEPTH];
  logic [IDX_W-1:0]    top_idx;
  logic [IDX_W-1:0]    push_idx;

  assign top_idx  = IDX_W'(sp_q - SP_W'(1));
  assign push_idx = IDX_W'(sp_q);

  always_comb begin
    sp_d    = sp_q;
    err_d   = err_q;
    stack_d = stack_q;
    exec_pc = pc_inc;
    if (state_q == S_EXEC) begin
      if (Ret) begin
        // Ret outranks Call; an empty pop falls through to PC+1 and flags the error.
        if (sp_q == '0) begin
          err_d = 1'b1;
        end else begin
          exec_pc = stack_q[top_idx];
          sp_d    = sp_q - SP_W'(1);
        end
      end else if (Call) begin
        exec_pc = jump_target;
        if (sp_q == SP_FULL) begin
          err_d = 1'b1;
        end else begin
          stack_d[push_idx] = pc_inc;
          sp_d              = sp_q + SP_W'(1);
        end
      end else if (jump_flag) begin
        exec_pc = jump_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q  <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      sp_q    <= sp_d;
      err_q   <= err_d;
      stack_q <= stack_d;
    end
  end

  assign StackErr = err_q;
`else
  logic unused_ok;

  assign exec_pc   = jump_flag ? jump_target : pc_inc;
  assign StackErr  = 1'b0;
  assign unused_ok = &{1'b0, Call, Ret, (STACK_DEPTH > 0)};
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    step_d      = step_q;
    step_done_d = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        pc_d = exec_pc;
        if (HaltReq || step_q) begin
          state_d     = S_HALT;
          step_done_d = step_q;
          step_d      = 1'b0;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (!HaltReq) begin
          state_d = S_FETCH;
        end else if (step_rise) begin
          state_d = S_FETCH;
          step_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      step_q      <= 1'b0;
      step_done_q <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      step_q      <= step_d;
      step_done_q <= step_done_d;
      step_prev_q <= step_prev_d;
    end
  end

  assign PC       = pc_q;
  assign Fetch_CE = (state_q == S_FETCH);
  assign Exec_CE  = (state_q == S_EXEC);
  assign Halted   = (state_q == S_HALT);
  assign StepDone = step_done_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic       clk;
  logic       rst;
  logic [6:0] ControlPC;
  logic       Call;
  logic       Ret;
  logic       HaltReq;
  logic       StepReq;
  logic [5:0] PC;
  logic       Fetch_CE;
  logic       Exec_CE;
  logic       Halted;
  logic       StepDone;
  logic       StackErr;

  int tests_run;
  int tests_failed;

  pc_sequencer #(.PC_WIDTH(6), .STACK_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .ControlPC(ControlPC),
    .Call     (Call),
    .Ret      (Ret),
    .HaltReq  (HaltReq),
    .StepReq  (StepReq),
    .PC       (PC),
    .Fetch_CE (Fetch_CE),
    .Exec_CE  (Exec_CE),
    .Halted   (Halted),
    .StepDone (StepDone),
    .StackErr (StackErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input int n);
    repeat (n) begin
      tick();
      tick();
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    ControlPC = '0;
    Call      = 1'b0;
    Ret       = 1'b0;
    HaltReq   = 1'b0;
    StepReq   = 1'b0;
    tick();
    tick();
    check("rst_pc", PC, 0);
    check("rst_fetch", Fetch_CE, 0);
    check("rst_exec", Exec_CE, 0);
    check("rst_halted", Halted, 0);
    check("rst_stepdone", StepDone, 0);
    check("rst_stackerr", StackErr, 0);

    rst = 1'b0;
    check("idle_fetch", Fetch_CE, 0);
    tick();
    for (int i = 0; i < 64; i++) begin
      check("seq_fetch", Fetch_CE, 1);
      check("seq_fetch_pc", PC, i);
      tick();
      check("seq_exec", Exec_CE, 1);
      check("seq_exec_pc", PC, i);
      tick();
    end
    check("wrap_pc", PC, 0);
    check("wrap_fetch", Fetch_CE, 1);

    // Jump with flag set at PC=5
    run_instr(5);
    check("at5_pc", PC, 5);
    tick();
    ControlPC = 7'b1_101010;
    tick();
    ControlPC = '0;
    check("jump_pc", PC, 42);
    check("jump_fetch", Fetch_CE, 1);
    tick();
    ControlPC = {1'b1, 6'd5};
    tick();
    ControlPC = {1'b0, 6'd42};
    tick();
    tick();
    check("nojump_pc", PC, 6);
    ControlPC = '0;

    // HaltReq during FETCH at PC=3
    tick();
    ControlPC = {1'b1, 6'd3};
    tick();
    ControlPC = '0;
    check("at3_fetch", Fetch_CE, 1);
    check("at3_pc", PC, 3);
    HaltReq = 1'b1;
    tick();
    check("halt_exec_runs", Exec_CE, 1);
    tick();
    check("halted", Halted, 1);
    check("halt_exec_off", Exec_CE, 0);
    check("halt_pc", PC, 4);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("halt_hold_pc", PC, 4);
      check("halt_hold_fetch", Fetch_CE, 0);
    end

    // Single step with StepReq held 5 cycles
    StepReq = 1'b1;
    check("step_c0_done", StepDone, 0);
    tick();
    check("step_c1_fetch", Fetch_CE, 1);
    check("step_c1_halted", Halted, 0);
    tick();
    check("step_c2_exec", Exec_CE, 1);
    tick();
    check("step_c3_halted", Halted, 1);
    check("step_c3_done", StepDone, 1);
    check("step_c3_pc", PC, 5);
    tick();
    check("step_c4_done", StepDone, 0);
    check("step_c4_halted", Halted, 1);
    StepReq = 1'b0;
    tick();
    check("step_c5_halted", Halted, 1);
    check("step_c5_pc", PC, 5);

    // Resume, then StepReq raised outside HALT is not queued
    HaltReq = 1'b0;
    tick();
    check("resume_fetch", Fetch_CE, 1);
    check("resume_pc", PC, 5);
    HaltReq = 1'b1;
    StepReq = 1'b1;
    tick();
    tick();
    check("halt2_halted", Halted, 1);
    check("halt2_pc", PC, 6);
    check("halt2_nodone", StepDone, 0);
    tick();
    check("noqueue_halted", Halted, 1);
    tick();
    check("noqueue_pc", PC, 6);
    StepReq = 1'b0;
    tick();
    StepReq = 1'b1;
    tick();
    tick();
    tick();
    check("step2_done", StepDone, 1);
    check("step2_pc", PC, 7);
    StepReq = 1'b0;
    HaltReq = 1'b0;
    tick();
    check("resume2_fetch", Fetch_CE, 1);

    // Reset during EXEC at PC=9 with a jump pending
    run_instr(2);
    tick();
    check("at9_exec", Exec_CE, 1);
    check("at9_pc", PC, 9);
    ControlPC = {1'b1, 6'd42};
    rst = 1'b1;
    tick();
    check("midrst_pc", PC, 0);
    check("midrst_fetch", Fetch_CE, 0);
    check("midrst_exec", Exec_CE, 0);
    check("midrst_halted", Halted, 0);
    rst = 1'b0;
    ControlPC = '0;
    tick();
    check("postrst_fetch", Fetch_CE, 1);
    check("postrst_pc", PC, 0);

    // Call with flag clear: ignored without the stack, loads target with it
    tick();
    Call = 1'b1;
    ControlPC = {1'b0, 6'd20};
    tick();
    Call = 1'b0;
    ControlPC = '0;
`ifdef SEQ_CALL_STACK_EN
    check("call_pc", PC, 20);
`else
    check("call_ignored_pc", PC, 1);
`endif
    check("call_stackerr", StackErr, 0);

`ifdef SEQ_CALL_STACK_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("stk_start_pc", PC, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      Call = 1'b1;
      ControlPC = {1'b0, 6'((k + 1) * 10)};
      tick();
      Call = 1'b0;
      ControlPC = '0;
      check("stk_call_pc", PC, (k + 1) * 10);
      check("stk_call_err", StackErr, (k == 4) ? 1 : 0);
    end
    for (int k = 0; k < 5; k++) begin
      int exp_pc;
      case (k)
        0: exp_pc = 31;
        1: exp_pc = 21;
        2: exp_pc = 11;
        3: exp_pc = 1;
        default: exp_pc = 2;
      endcase
      tick();
      Ret = 1'b1;
      tick();
      Ret = 1'b0;
      check("stk_ret_pc", PC, exp_pc);
      check("stk_ret_err", StackErr, 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Two-phase fetch/execute controller for the uProcessor core. It owns the 6-bit program counter, sequences each instruction through a FETCH cycle, which loads the instruction register, and an EXEC cycle, which qualifies the datapath write enables. It applies the jump request `{flag, addr}` produced by the instruction decoder. It also provides a halt / single-step debug handshake so a bench or debug port can freeze and step the core.

## Interface
Parameters:
- `PC_WIDTH`, default 6: program counter width; program memory depth is 2^`PC_WIDTH`.
- `STACK_DEPTH`, default 4: return-stack entries. Used only with `SEQ_CALL_STACK_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `ControlPC`  in  `PC_WIDTH`+1  decoder jump request: bit `PC_WIDTH` is the jump flag, bits `PC_WIDTH`-1:0 are the target.
- `Call`  in  1  decoder call strobe; push PC+1, then jump to the target.
- `Ret`  in  1  decoder return strobe; pop the stack into PC.
- `HaltReq`  in  1  level-sensitive; request to stop at the next instruction boundary.
- `StepReq`  in  1  single-step request; honoured only in HALT.
- `PC`  out  `PC_WIDTH`  program memory address; registered.
- `Fetch_CE`  out  1  instruction register load enable.
- `Exec_CE`  out  1  qualifier ANDed into Accu_CE, Carry_CE, Reg_CE and DataMem_WE.
- `Halted`  out  1  high while in HALT.
- `StepDone`  out  1  one-cycle pulse when a single step completes.
- `StackErr`  out  1  sticky stack overflow/underflow flag.

## Operation
- FSM states: IDLE, FETCH, EXEC, HALT. The state is registered; `Fetch_CE`, `Exec_CE` and `Halted` decode directly from the state.
- While `rst`=1, or on the first edge after it, the state is IDLE and all of these are 0: `PC`, `Fetch_CE`, `Exec_CE`, `Halted`, `StepDone`, `StackErr`, and the stack pointer.
- IDLE → FETCH unconditionally.
- FETCH: `Fetch_CE`=1; `PC` holds. FETCH → EXEC always; a fetch is never aborted.
- EXEC: `Exec_CE`=1. `PC` updates at the end of the cycle, with this priority:
  1. `Ret`
  2. `Call`
  3. `ControlPC` flag set: `PC` ← target
  4. otherwise `PC` ← `PC`+1, modulo 2^`PC_WIDTH` (63 → 0)
- EXEC exit: if `HaltReq`=1 or a step is in progress, go to HALT; otherwise go to FETCH.
- HALT: `Halted`=1; `PC` holds; no enables are asserted.
  - `HaltReq`=0: go to FETCH (resume).
  - `HaltReq`=1 and `StepReq`=1: go to FETCH and mark a step in progress.
  - `StepReq` is edge-detected internally. A level held high yields exactly one step.
- Step completion: on the EXEC → HALT transition of a step, `StepDone` pulses for 1 cycle, coincident with the first HALT cycle.
- `HaltReq` asserted during FETCH does not abort the instruction. The instruction completes its EXEC, then the FSM halts.
- `rst` mid-instruction returns to IDLE on the next edge. The partially executed instruction's EXEC never occurs.
- Without the call stack, `Call` and `Ret` are ignored. `Call` still jumps if the `ControlPC` flag is set.

## Timing
- Throughput is 2 cycles per instruction, and the first FETCH follows the IDLE cycle after `rst` falls.
- `PC` changes only on the EXEC → next edge. The new `PC` is valid at the following FETCH.
- A jump takes effect with no delay slot: the instruction after a jump comes from the target.
- `HaltReq` sampled high in EXEC gives `Halted`=1 on the next cycle.
- From HALT, a `StepReq` rising edge gives this sequence: FETCH on the next cycle, then EXEC, then HALT with `StepDone`=1. This is 3 cycles from request to `StepDone`.
- `StepReq` asserted outside HALT is ignored and not queued.

## Configuration
- `SEQ_CALL_STACK_EN` defined:
  - A `STACK_DEPTH`-entry LIFO of `PC_WIDTH`-bit return addresses is implemented.
  - `Call` in EXEC pushes (`PC`+1) mod 2^`PC_WIDTH` and loads the target.
  - `Ret` in EXEC pops into `PC`.
  - Push when full: no write, `PC` still jumps, `StackErr` ← 1.
  - Pop when empty: `PC` ← `PC`+1, `StackErr` ← 1.
  - `StackErr` clears only on `rst`.
  - `Call` and `Ret` together: `Ret` wins, and there is no push.
- `SEQ_CALL_STACK_EN` undefined:
  - No stack storage is built.
  - `Call` and `Ret` are ignored.
  - `StackErr` is tied to 0.

## Test plan
- Reset then run with no jumps: the `PC` sequence is 0, 0, 1, 1, 2…. `Fetch_CE`/`Exec_CE` alternate starting one cycle after `rst` falls. After 64 instructions `PC` wraps 63 → 0.
- `ControlPC`=7'b1_101010 during EXEC at `PC`=5: the next FETCH has `PC`=42. With the flag clear, the next FETCH has `PC`=6.
- `HaltReq` rises during FETCH at `PC`=3: EXEC still occurs and `PC` becomes 4. `Halted`=1 follows with `Exec_CE`=0, and `PC` stays at 4 for 20 cycles.
- In HALT, hold `StepReq` high for 5 cycles: exactly one FETCH/EXEC pair occurs, `PC` goes 4 → 5, and `StepDone` pulses once, 3 cycles after the `StepReq` edge. Dropping `HaltReq` then resumes continuous execution.
- `rst` asserted during EXEC at `PC`=9 with the jump flag set: the state returns to IDLE, `PC`=0, and no jump is taken.
- With `SEQ_CALL_STACK_EN`: 5 nested `Call` instructions to 10, 20, 30, 40, 50 occur. The fifth sets `StackErr`=1 and still jumps to 50. 5 `Ret` instructions then return to the 4 pushed addresses in reverse order. The final pop is empty, so `PC` advances by 1 and `StackErr` stays 1.
